// File: rtl/serial_signed_adder.sv
// serial_signed_adder: bit-serial signed adder, one full-adder slice per clock.
// Computes a + b + cin LSB first over SIZE cycles and reports the wrapped sum,
// carry out, signed overflow and the exact SIZE+1-bit signed answer.
// Optional macro SERIAL_ADDER_SATURATE_EN clamps sum to the signed range on overflow.
module serial_signed_adder #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic            ready,
  output logic            done,
  output logic [SIZE-1:0] sum,
  output logic            cout,
  output logic            overflow,
  output logic [SIZE:0]   answer
);

  localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [SIZE-1:0] a_sh;
  logic [SIZE-1:0] b_sh;
  logic [SIZE-2:0] res_sh;
  logic            carry;
  logic [CW-1:0]   count;

  logic            bit_s;
  logic            maj;
  logic            ovf_next;
  logic [SIZE-1:0] raw_sum;
  logic [SIZE-1:0] final_sum;

  // State register; reset forces IDLE and wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs: ready only in IDLE, done only in DONE.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        if (count == LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Single full-adder slice; the carry register at the last step is the carry into the MSB.
  always_comb begin
    bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
    maj      = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    ovf_next = carry ^ maj;
    raw_sum  = {bit_s, res_sh};
  end

`ifdef SERIAL_ADDER_SATURATE_EN
  // On overflow both operand MSBs agree, so the MSB of a gives the overflow direction.
  always_comb begin
    final_sum = raw_sum;
    if (ovf_next) begin
      final_sum = a_sh[0] ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
    end
  end
`else
  assign final_sum = raw_sum;
`endif

  // Datapath: load operands on accept, shift one bit per RUN cycle, publish results on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      answer   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
          end
        end
        RUN: begin
          carry  <= maj;
          res_sh <= raw_sum[SIZE-1:1];
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          count  <= count + CW'(1);
          if (count == LAST) begin
            sum      <= final_sum;
            cout     <= maj;
            overflow <= ovf_next;
            answer   <= {a_sh[0] ^ b_sh[0] ^ maj, raw_sum};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_signed_adder.sv
// tb_serial_signed_adder: table-driven and scoreboard bench for serial_signed_adder (SIZE=4).
// Expected results are pushed when a start is driven and popped when done is seen.
module tb_serial_signed_adder;

  localparam int SIZE = 4;
`ifdef SERIAL_ADDER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       ready;
  logic       done;
  logic [3:0] sum;
  logic       cout;
  logic       overflow;
  logic [4:0] answer;

  typedef struct {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic [4:0] ans;
  } res_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] raw;
    logic       cout;
    logic       ovf;
    logic [4:0] ans;
  } vec_t;

  res_t       sb_q[$];
  vec_t       vecs[8];
  int         checks = 0;
  int         passed = 0;
  logic [3:0] last_sum = 4'd0;

  serial_signed_adder #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .done(done), .sum(sum), .cout(cout),
    .overflow(overflow), .answer(answer)
  );

  always #5 clk = ~clk;

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] clampSum(logic [3:0] raw, logic ovf, logic [4:0] ans);
    if (SAT && ovf) return ans[4] ? 4'b1000 : 4'b0111;
    return raw;
  endfunction

  // Integer reference model of sext(a)+sext(b)+cin.
  function automatic res_t model(logic [3:0] xa, logic [3:0] xb, logic xc);
    res_t r;
    int   sa, sb, ex, u;
    sa    = int'($signed(xa));
    sb    = int'($signed(xb));
    ex    = sa + sb + int'(xc);
    u     = int'(xa) + int'(xb) + int'(xc);
    r.ans  = ex[4:0];
    r.cout = u[4];
    r.ovf  = (ex > 7) || (ex < -8);
    r.sum  = clampSum(ex[3:0], r.ovf, ex[4:0]);
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
  endtask

  // Waits (bounded) for IDLE, then drives one start for the next edge and records the expectation.
  task automatic applyStimulus(input logic [3:0] xa, input logic [3:0] xb, input logic xc,
                               input res_t exp_r);
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    checkOutput("ready_before_start", int'(ready), 1);
    start = 1'b1;
    a     = xa;
    b     = xb;
    cin   = xc;
    sb_q.push_back(exp_r);
  endtask

  // Waits for done; checks latency, busy flags, result hold, and the popped expectation.
  task automatic waitResult(input string name, input bit busy_pulse);
    bit   found = 1'b0;
    int   lat = 0;
    res_t e;
    for (int i = 1; i <= SIZE + 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      a     = 4'($urandom);
      b     = 4'($urandom);
      cin   = 1'($urandom);
      if (done) begin
        found = 1'b1;
        lat   = i;
        break;
      end
      checkOutput({name, "_ready_busy"}, int'(ready), 0);
      checkOutput({name, "_sum_hold"}, int'(sum), int'(last_sum));
      if (busy_pulse && i == 2) begin
        start = 1'b1;
        a     = 4'd5;
        b     = 4'd5;
        cin   = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput({name, "_done_seen"}, int'(found), 1);
    if (found) begin
      checkOutput({name, "_latency"}, lat, SIZE + 1);
      if (sb_q.size() == 0) begin
        checkOutput({name, "_scoreboard_nonempty"}, 0, 1);
      end else begin
        e = sb_q.pop_front();
        checkOutput({name, "_sum"},      int'(sum),      int'(e.sum));
        checkOutput({name, "_cout"},     int'(cout),     int'(e.cout));
        checkOutput({name, "_overflow"}, int'(overflow), int'(e.ovf));
        checkOutput({name, "_answer"},   int'(answer),   int'(e.ans));
        last_sum = e.sum;
      end
      @(negedge clk);
      checkOutput({name, "_done_one_cycle"}, int'(done), 0);
      checkOutput({name, "_ready_after"}, int'(ready), 1);
    end
  endtask

  initial begin
    int   extra;
    res_t e;

    // {a, b, cin, raw sum, cout, overflow, answer}
    vecs[0] = '{4'd3,    4'd2,    1'b0, 4'b0101, 1'b0, 1'b0, 5'b00101};
    vecs[1] = '{4'd7,    4'd1,    1'b0, 4'b1000, 1'b0, 1'b1, 5'b01000};
    vecs[2] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 5'b10000};
    vecs[3] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 5'b00000};
    vecs[4] = '{4'b1101, 4'b1110, 1'b1, 4'b1100, 1'b1, 1'b0, 5'b11100};
    vecs[5] = '{4'd5,    4'd6,    1'b1, 4'b1100, 1'b0, 1'b1, 5'b01100};
    vecs[6] = '{4'b1000, 4'd7,    1'b0, 4'b1111, 1'b0, 1'b0, 5'b11111};
    vecs[7] = '{4'b1100, 4'b1011, 1'b0, 4'b0111, 1'b1, 1'b1, 5'b10111};

    rst   = 1'b1;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    cin   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready",    int'(ready),    1);
    checkOutput("reset_done",     int'(done),     0);
    checkOutput("reset_sum",      int'(sum),      0);
    checkOutput("reset_cout",     int'(cout),     0);
    checkOutput("reset_overflow", int'(overflow), 0);
    checkOutput("reset_answer",   int'(answer),   0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      e.sum  = clampSum(vecs[i].raw, vecs[i].ovf, vecs[i].ans);
      e.cout = vecs[i].cout;
      e.ovf  = vecs[i].ovf;
      e.ans  = vecs[i].ans;
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, e);
      waitResult($sformatf("vec%0d", i), 1'b0);
    end

    $display("[TB] random vectors");
    for (int i = 0; i < 6; i++) begin
      logic [3:0] ra, rb;
      logic       rc;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, model(ra, rb, rc));
      waitResult($sformatf("rand%0d", i), 1'b0);
    end

    $display("[TB] busy start ignored");
    applyStimulus(4'd2, 4'd3, 1'b0, model(4'd2, 4'd3, 1'b0));
    waitResult("busy", 1'b1);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checkOutput("busy_no_second_done", extra, 0);

    $display("[TB] reset mid-run");
    applyStimulus(4'd6, 4'd1, 1'b0, model(4'd6, 4'd1, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb_q.pop_back());
    last_sum = 4'd0;
    checkOutput("midreset_ready",    int'(ready),    1);
    checkOutput("midreset_done",     int'(done),     0);
    checkOutput("midreset_sum",      int'(sum),      0);
    checkOutput("midreset_cout",     int'(cout),     0);
    checkOutput("midreset_overflow", int'(overflow), 0);
    checkOutput("midreset_answer",   int'(answer),   0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checkOutput("midreset_no_done", extra, 0);
    applyStimulus(4'd4, 4'b1110, 1'b1, model(4'd4, 4'b1110, 1'b1));
    waitResult("after_reset", 1'b0);

    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
